// File: rtl/port_uart_tx_if.sv
// Byte-strobe and status bundle between the CPU output port and the UART transmitter.
interface port_uart_tx_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_ovf;
  logic       tx;
  logic       busy;
  logic       fifo_full;
  logic       fifo_empty;
  logic       overflow;
  logic [7:0] status;

  modport master (
    output wr_en, wr_data, clr_ovf,
    input  tx, busy, fifo_full, fifo_empty, overflow, status
  );

  modport slave (
    input  wr_en, wr_data, clr_ovf,
    output tx, busy, fifo_full, fifo_empty, overflow, status
  );
endinterface

// File: rtl/port_uart_tx.sv
// FIFO-buffered 8N1 serial transmitter for the CPU output port at 0x800.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module port_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          reset,
  port_uart_tx_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state, state_next;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    shift_reg, shift_next;
  logic [2:0]    bit_idx, bit_next;
  logic [BW-1:0] baud, baud_next;
  logic          tx_reg, tx_next;
  logic          overflow_reg;
  logic          pop, push_ok, drop, baud_done;
`ifdef UART_TX_PARITY_EN
  logic [7:0]    data_byte;
`endif

  // A push into a full FIFO still fits when the transmitter pops in the same cycle.
  assign push_ok   = bus.wr_en && ((count != FULL_COUNT) || pop);
  assign drop      = bus.wr_en && !push_ok;
  assign baud_done = (baud == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)             overflow_reg <= 1'b1;
      else if (bus.clr_ovf) overflow_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_idx   <= '0;
      baud      <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      bit_idx   <= bit_next;
      baud      <= baud_next;
      tx_reg    <= tx_next;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    data_byte <= '0;
    else if (pop) data_byte <= mem[rd_ptr];
  end
`endif

  // tx_next is the line level for the state being entered, so tx stays a clean flop output.
  always_comb begin
    state_next = state;
    shift_next = shift_reg;
    bit_next   = bit_idx;
    baud_next  = baud;
    tx_next    = 1'b1;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          bit_next   = '0;
          baud_next  = '0;
          tx_next    = 1'b0;
          state_next = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (baud_done) begin
          baud_next  = '0;
          tx_next    = shift_reg[0];
          state_next = DATA;
        end else begin
          baud_next = baud + 1'b1;
        end
      end
      DATA: begin
        tx_next = shift_reg[0];
        if (baud_done) begin
          baud_next = '0;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_next    = ^data_byte;
            state_next = PARITY;
`else
            tx_next    = 1'b1;
            state_next = STOP;
`endif
          end else begin
            shift_next = shift_reg >> 1;
            bit_next   = bit_idx + 3'd1;
            tx_next    = shift_reg[1];
          end
        end else begin
          baud_next = baud + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_next = ^data_byte;
        if (baud_done) begin
          baud_next  = '0;
          tx_next    = 1'b1;
          state_next = STOP;
        end else begin
          baud_next = baud + 1'b1;
        end
      end
`endif
      STOP: begin
        tx_next = 1'b1;
        if (baud_done) begin
          baud_next  = '0;
          state_next = IDLE;
        end else begin
          baud_next = baud + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.tx         = tx_reg;
  assign bus.busy       = (state != IDLE);
  assign bus.fifo_full  = (count == FULL_COUNT);
  assign bus.fifo_empty = (count == '0);
  assign bus.overflow   = overflow_reg;
  assign bus.status     = {4'b0000, overflow_reg, bus.busy, bus.fifo_full, bus.fifo_empty};
endmodule

// File: tb/tb_port_uart_tx.sv
// Self-checking bench for port_uart_tx: directed scenarios plus random pushes against a
// frame-schedule reference model (line level derived from pop time and bit position).
module tb_port_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int BITS_PER_FRAME = 11;
`else
  localparam int BITS_PER_FRAME = 10;
`endif
  localparam int FRAME = BITS_PER_FRAME * CPB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  port_uart_tx_if bus();

  port_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: bytes waiting in the FIFO, and the edge on which the current frame began.
  logic [7:0] pend[$];
  logic [7:0] cur_byte = 8'h00;
  int         cyc = 0;
  int         pop_cyc = 0;
  bit         have_frame = 1'b0;
  bit         m_ovf = 1'b0;
  bit         m_idle, m_pop, m_accept, m_in_frame;
  logic       m_tx = 1'b1;
  logic [7:0] m_status = 8'h01;

  function automatic logic line_level(input int offset, input logic [7:0] b);
    int k;
    k = offset / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pend.delete();
      have_frame = 1'b0;
      m_ovf      = 1'b0;
      cyc        = 0;
      pop_cyc    = 0;
    end else begin
      cyc++;
      m_idle   = !have_frame || (cyc > pop_cyc + FRAME);
      m_pop    = m_idle && (pend.size() != 0);
      m_accept = bus.wr_en && ((pend.size() < DEPTH) || m_pop);
      if (m_pop) begin
        cur_byte   = pend.pop_front();
        pop_cyc    = cyc;
        have_frame = 1'b1;
      end
      if (m_accept) pend.push_back(bus.wr_data);
      if (bus.wr_en && !m_accept) m_ovf = 1'b1;
      else if (bus.clr_ovf)       m_ovf = 1'b0;
    end
    m_in_frame = have_frame && ((cyc - pop_cyc) < FRAME);
    m_tx       = m_in_frame ? line_level(cyc - pop_cyc, cur_byte) : 1'b1;
    m_status   = {4'b0000, m_ovf, m_in_frame, pend.size() == DEPTH, pend.size() == 0};
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("tx", {7'b0, bus.tx}, {7'b0, m_tx});
      checkOutput("status", bus.status, m_status);
      checkOutput("flags", {4'b0, bus.overflow, bus.busy, bus.fifo_full, bus.fifo_empty}, m_status);
    end
  end

  task automatic applyStimulus(input logic we, input logic [7:0] d, input logic c);
    @(negedge clk);
    bus.wr_en   = we;
    bus.wr_data = d;
    bus.clr_ovf = c;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.clr_ovf = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idleCycles(20);

    applyStimulus(1'b1, 8'hA5, 1'b0);
    idleCycles(FRAME + 10);

    applyStimulus(1'b1, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    applyStimulus(1'b1, 8'h3C, 1'b0);
    idleCycles(3 * FRAME + 10);

    // Six back-to-back pushes: one pops, four fill, the last is dropped.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'h10 + 8'(i), 1'b0);
    idleCycles(4);
    applyStimulus(1'b0, 8'h00, 1'b1);
    idleCycles(2);
    applyStimulus(1'b1, 8'hEE, 1'b1);
    idleCycles(2);
    applyStimulus(1'b0, 8'h00, 1'b1);
    idleCycles(5 * FRAME + 10);

    applyStimulus(1'b1, 8'h5A, 1'b0);
    idleCycles(15);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("tx_async_reset", {7'b0, bus.tx}, 8'h01);
    checkOutput("status_async_reset", bus.status, 8'h01);
    @(negedge clk);
    #2 reset = 1'b0;
    idleCycles(FRAME + 10);

`ifdef UART_TX_PARITY_EN
    applyStimulus(1'b1, 8'h07, 1'b0);
    idleCycles(FRAME + 5);
    applyStimulus(1'b1, 8'h03, 1'b0);
    idleCycles(FRAME + 5);
`endif

    for (int i = 0; i < 600; i++)
      applyStimulus($urandom_range(0, 99) < 6, 8'($urandom), $urandom_range(0, 99) < 3);
    for (int i = 0; i < 300; i++)
      applyStimulus($urandom_range(0, 99) < 40, 8'($urandom), $urandom_range(0, 99) < 5);
    idleCycles((DEPTH + 2) * (FRAME + 1) + 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
